// File: rtl/morphle_pkg.sv
// Shared definitions for the Morphle Logic configuration chain: cell codes and
// the streamer phase enum.
package morphle_pkg;

  localparam logic [2:0] CFG_SPACE = 3'b000;
  localparam logic [2:0] CFG_PLUS  = 3'b001;
  localparam logic [2:0] CFG_MINUS = 3'b010;
  localparam logic [2:0] CFG_BAR   = 3'b011;
  localparam logic [2:0] CFG_ONE   = 3'b100;
  localparam logic [2:0] CFG_ZERO  = 3'b101;
  localparam logic [2:0] CFG_Y     = 3'b110;
  localparam logic [2:0] CFG_N     = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow
  } state_e;

endpackage

// File: rtl/ycconf_tick.sv
// Phase timer: reloads ClkDiv-1 when a phase starts and flags the last cycle
// of the phase when the count reaches zero.
module ycconf_tick #(
  parameter int unsigned ClkDiv = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  output logic phase_done_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = 8'(ClkDiv - 1);
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_done_o = (cnt_q == 8'd0);

endmodule

// File: rtl/ycconf_streamer.sv
// Serializes 3-bit cell codes MSB first into the configuration chain while
// reassembling the codes that fall out of the far end.
module ycconf_streamer
  import morphle_pkg::*;
#(
  parameter int unsigned CLKDIV = 2,
  parameter int unsigned NCELLS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  output logic       confclk,
  output logic       cbitin,
  input  logic       cbitout,
  output logic       out_valid,
  output logic [2:0] out_code,
  output logic       busy,
  output logic       loaded
);

  localparam int unsigned CntW = $clog2(NCELLS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(NCELLS);

  state_e state_q, state_d;
  logic [2:0] sreg_q, sreg_d, rreg_q, rreg_d;
  logic [1:0] bit_q, bit_d;
  logic       cbit_q, cbit_d, conf_q, conf_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic       phase_done, tick_start, last_bit;

  assign last_bit   = (bit_q == 2'd0);
  // Every phase boundary, and the handshake itself, restarts the timer.
  assign tick_start = (state_q == StIdle) ? in_valid : phase_done;

  ycconf_tick #(
    .ClkDiv(CLKDIV)
  ) u_tick (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (tick_start),
    .phase_done_o(phase_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StSetup;
      StSetup: if (phase_done) state_d = StHigh;
      StHigh:  if (phase_done) state_d = StLow;
      StLow:   if (phase_done) state_d = last_bit ? StIdle : StSetup;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    out_valid = (state_q == StLow) && phase_done && last_bit;
    out_code  = rreg_q;
    confclk   = conf_q;
    cbitin    = cbit_q;
    loaded    = (cnt_q == CntMax);
  end

  // cbitin only moves on SETUP entry so it is stable across the whole pulse.
  always_comb begin
    sreg_d = sreg_q;
    rreg_d = rreg_q;
    bit_d  = bit_q;
    cbit_d = cbit_q;
    cnt_d  = cnt_q;
    conf_d = (state_d == StHigh);
    if (state_q == StIdle && in_valid) begin
      sreg_d = in_code;
      bit_d  = 2'd2;
      cbit_d = in_code[2];
    end
    if (state_q == StSetup && phase_done) begin
      rreg_d[bit_q] = cbitout;
    end
    if (state_q == StLow && phase_done && !last_bit) begin
      bit_d  = bit_q - 2'd1;
      cbit_d = sreg_q[bit_q - 2'd1];
    end
    if (out_valid && cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_q <= '0;
      rreg_q <= '0;
      bit_q  <= '0;
      cbit_q <= 1'b0;
      conf_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      rreg_q <= rreg_d;
      bit_q  <= bit_d;
      cbit_q <= cbit_d;
      conf_q <= conf_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ycconf_streamer.sv
// Directed bench: two streamers (CLKDIV=2/NCELLS=2 and CLKDIV=1) each driving a
// behavioural two-cell chain.
module tb_ycconf_streamer;
  import morphle_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       iv_a, ir_a, conf_a, cbit_a, cbo_a, ova_a, busy_a, ld_a;
  logic [2:0] ic_a, oc_a;
  logic       iv_b, ir_b, conf_b, cbit_b, cbo_b, ova_b, busy_b, ld_b;
  logic [2:0] ic_b, oc_b;

  ycconf_streamer #(.CLKDIV(2), .NCELLS(2)) dut_a (
    .clk(clk), .reset(reset), .in_valid(iv_a), .in_code(ic_a), .in_ready(ir_a),
    .confclk(conf_a), .cbitin(cbit_a), .cbitout(cbo_a), .out_valid(ova_a),
    .out_code(oc_a), .busy(busy_a), .loaded(ld_a)
  );

  ycconf_streamer #(.CLKDIV(1), .NCELLS(16)) dut_b (
    .clk(clk), .reset(reset), .in_valid(iv_b), .in_code(ic_b), .in_ready(ir_b),
    .confclk(conf_b), .cbitin(cbit_b), .cbitout(cbo_b), .out_valid(ova_b),
    .out_code(oc_b), .busy(busy_b), .loaded(ld_b)
  );

  // Two-cell chain model: {cell2, cell1}, bits enter cell1 LSB, leave cell2 MSB.
  logic [5:0] sr_a = '0;
  logic [5:0] sr_b = '0;
  int         rises_a = 0;
  int         rises_b = 0;
  logic [2:0] bits_b = '0;

  always @(posedge conf_a) begin
    sr_a    <= {sr_a[4:0], cbit_a};
    rises_a <= rises_a + 1;
  end

  always @(posedge conf_b) begin
    sr_b    <= {sr_b[4:0], cbit_b};
    bits_b  <= {bits_b[1:0], cbit_b};
    rises_b <= rises_b + 1;
  end

  assign cbo_a = sr_a[5];
  assign cbo_b = sr_b[5];

  int n_vec = 0;
  int n_err = 0;

  logic [2:0] codes  [8] = '{CFG_SPACE, CFG_PLUS, CFG_MINUS, CFG_BAR,
                             CFG_ONE, CFG_ZERO, CFG_Y, CFG_N};
  int         exp_rb [8] = '{0, 0, 0, 1, 2, 3, 4, 5};
  int         exp_c2 [8] = '{0, 0, 1, 2, 3, 4, 5, 6};
  int         exp_ld [8] = '{0, 1, 1, 1, 1, 1, 1, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts on a negedge in IDLE; ends on the negedge of the IDLE cycle after out_valid.
  task automatic send_a(input logic [2:0] code, output int lat, output int highs,
                        output int rises, output logic [2:0] rb);
    int r0;
    chk("ready_pre", 32'(ir_a), 1);
    iv_a  = 1'b1;
    ic_a  = code;
    r0    = rises_a;
    lat   = 0;
    highs = 0;
    @(posedge clk);
    do begin
      @(negedge clk);
      iv_a  = 1'b0;
      ic_a  = 3'b000;
      lat++;
      highs += int'(conf_a);
    end while (!ova_a && lat < 100);
    rb = oc_a;
    @(negedge clk);
    chk("ov_pulse", 32'(ova_a), 0);
    rises = rises_a - r0;
  endtask

  initial begin
    int lat, highs, rises, bad, nov, r0;
    logic [2:0] rb;

    reset = 1'b1;
    iv_a = 1'b0; ic_a = '0;
    iv_b = 1'b0; ic_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_confclk", 32'(conf_a), 0);
    chk("rst_cbitin", 32'(cbit_a), 0);
    chk("rst_in_ready", 32'(ir_a), 1);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_out_valid", 32'(ova_a), 0);
    chk("rst_out_code", 32'(oc_a), 0);
    chk("rst_loaded", 32'(ld_a), 0);
    chk("rst_in_ready_b", 32'(ir_b), 1);
    reset = 1'b0;
    @(negedge clk);

    // All eight codes back to back; read-back lags by two codes.
    for (int i = 0; i < 8; i++) begin
      send_a(codes[i], lat, highs, rises, rb);
      chk($sformatf("latency%0d", i), lat, 18);
      chk($sformatf("high_cycles%0d", i), highs, 6);
      chk($sformatf("rises%0d", i), rises, 3);
      chk($sformatf("readback%0d", i), 32'(rb), exp_rb[i]);
      chk($sformatf("cell1_%0d", i), 32'(sr_a[2:0]), 32'(codes[i]));
      chk($sformatf("cell2_%0d", i), 32'(sr_a[5:3]), exp_c2[i]);
      chk($sformatf("loaded%0d", i), 32'(ld_a), exp_ld[i]);
    end

    // in_valid held with a changing code while busy.
    chk("ready_hold_pre", 32'(ir_a), 1);
    iv_a = 1'b1;
    ic_a = CFG_PLUS;
    lat  = 0;
    bad  = 0;
    @(posedge clk);
    do begin
      @(negedge clk);
      ic_a = ic_a + 3'd3;
      lat++;
      if (ir_a) bad++;
    end while (!ova_a && lat < 100);
    rb   = oc_a;
    iv_a = 1'b0;
    @(negedge clk);
    chk("hold_ready_low", bad, 0);
    chk("hold_latency", lat, 18);
    chk("hold_readback", 32'(rb), 6);
    chk("hold_cell1", 32'(sr_a[2:0]), 1);
    chk("hold_cell2", 32'(sr_a[5:3]), 7);

    // Reset during HIGH of bit 1.
    iv_a = 1'b1;
    ic_a = CFG_N;
    @(posedge clk);
    @(negedge clk);
    iv_a = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_high_b1", 32'(conf_a), 1);
    chk("mid_cbitin_b1", 32'(cbit_a), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_confclk", 32'(conf_a), 0);
    chk("mrst_cbitin", 32'(cbit_a), 0);
    chk("mrst_in_ready", 32'(ir_a), 1);
    chk("mrst_busy", 32'(busy_a), 0);
    chk("mrst_out_valid", 32'(ova_a), 0);
    chk("mrst_out_code", 32'(oc_a), 0);
    chk("mrst_loaded", 32'(ld_a), 0);
    @(negedge clk);
    reset = 1'b0;
    nov = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      nov += int'(ova_a);
    end
    chk("mrst_no_out_valid", nov, 0);
    chk("mrst_still_idle", 32'(ir_a), 1);

    // CLKDIV=1: shift Y.
    chk("b_ready_pre", 32'(ir_b), 1);
    iv_b = 1'b1;
    ic_b = CFG_Y;
    r0   = rises_b;
    lat  = 0;
    @(posedge clk);
    do begin
      @(negedge clk);
      iv_b = 1'b0;
      lat++;
    end while (!ova_b && lat < 100);
    chk("b_latency", lat, 9);
    chk("b_rise_bits", 32'(bits_b), 32'(3'b110));
    chk("b_rises", rises_b - r0, 3);
    chk("b_cell1", 32'(sr_b[2:0]), 32'(CFG_Y));
    chk("b_readback", 32'(oc_b), 0);
    @(negedge clk);
    chk("b_idle_after", 32'(ir_b), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
